// File: rtl/cache_repl_pkg.sv
// ============================================================================
// cache_repl_pkg : LFSR tap table and replacement policy encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package cache_repl_pkg;

  typedef enum logic {
    POLICY_PLRU = 1'b0,
    POLICY_RAND = 1'b1
  } repl_policy_e;

  // Maximal-length Fibonacci tap masks, one bit set per tapped stage
  function automatic logic [31:0] lfsr_taps(input int len);
    case (len)
      16:      return 32'h0000_B400;
      32:      return 32'h8020_0003;
      default: return 32'h0000_00B8;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/cache_lfsr.sv
// ============================================================================
// cache_lfsr : left-shifting Fibonacci LFSR with enable and reset seed
// Rev 1.0
// ============================================================================
`default_nettype none

module cache_lfsr #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0] SEED      = WIDTH'(1),
  parameter int               OUT_WIDTH = WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  output logic [OUT_WIDTH-1:0] state
);

  logic [WIDTH-1:0] lfsr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      lfsr <= SEED;
    else if (enable)
      lfsr <= {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
  end

  assign state = lfsr[OUT_WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/cache_repl_policy.sv
// ============================================================================
// cache_repl_policy : per-set victim selection, tree PLRU or LFSR random
// Rev 1.0
// ============================================================================
`default_nettype none

module cache_repl_policy
  import cache_repl_pkg::*;
#(
  parameter int NUMWAYS  = 4,
  parameter int SETLEN   = 7,
  parameter int NUMLINES = 128,
  parameter int LFSRLEN  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               CacheEn,
  input  logic               FlushStage,
  input  logic [NUMWAYS-1:0] ValidWay,
  input  logic [NUMWAYS-1:0] HitWay,
  input  logic [SETLEN-1:0]  CacheSetData,
  input  logic [SETLEN-1:0]  PAdr,
  input  logic               LRUWriteEn,
  input  logic               SetValid,
  input  logic               InvalidateCache,
  input  logic               PolicySel,
  output logic [NUMWAYS-1:0] VictimWay
);

  generate
    if (NUMWAYS == 1) begin : g_single
      assign VictimWay = 1'b1;
    end else begin : g_multi
      localparam int L     = $clog2(NUMWAYS);
      localparam int NODEW = (NUMWAYS > 2) ? $clog2(NUMWAYS - 1) : 1;
      localparam logic [LFSRLEN-1:0] TAPS = LFSRLEN'(lfsr_taps(LFSRLEN));

      logic [NUMWAYS-2:0] mem [NUMLINES];
      logic [NUMWAYS-2:0] curr;
      logic [NUMWAYS-2:0] next;
      logic [L-1:0]       lfsr_way;
      logic [L-1:0]       plru_way;
      logic [L-1:0]       acc_way;
      logic [NUMWAYS-1:0] acc_onehot;
      logic [NUMWAYS-1:0] invalid;
      logic [NUMWAYS-1:0] first_invalid;
      logic [NUMWAYS-1:0] victim;
      logic               write_en;
      logic               clear_en;
      logic               fwd;

      assign write_en = LRUWriteEn & ~FlushStage;
      assign clear_en = InvalidateCache & ~FlushStage;
      assign fwd      = write_en & (PAdr == CacheSetData);

      cache_lfsr #(
        .WIDTH     (LFSRLEN),
        .TAPS      (TAPS),
        .SEED      (LFSRLEN'(1)),
        .OUT_WIDTH (L)
      ) u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .enable (write_en & SetValid),
        .state  (lfsr_way)
      );

      // Isolate the lowest set bit of the invalid mask
      assign invalid       = ~ValidWay;
      assign first_invalid = invalid & (~invalid + NUMWAYS'(1));

      // Walk from the root; each node bit picks the child, appended as way bit
      always_comb begin
        logic [NODEW-1:0] node;
        node     = '0;
        plru_way = '0;
        for (int l = 0; l < L; l++) begin
          node     = NODEW'((1 << l) - 1) + NODEW'(plru_way);
          plru_way = (plru_way << 1) | L'(curr[node]);
        end
      end

      always_comb begin
        victim = '0;
        if (~&ValidWay)
          victim = first_invalid;
        else if (repl_policy_e'(PolicySel) == POLICY_PLRU)
          victim[plru_way] = 1'b1;
        else
          victim[lfsr_way] = 1'b1;
      end

      assign VictimWay = victim;

      always_comb begin
        acc_onehot = SetValid ? victim : HitWay;
        acc_way    = '0;
        for (int w = 0; w < NUMWAYS; w++)
          if (acc_onehot[w]) acc_way = acc_way | L'(w);
      end

      // Nodes along the accessed path are flipped to point away from it
      always_comb begin
        logic [NODEW-1:0] node;
        node = '0;
        next = curr;
        for (int l = 0; l < L; l++) begin
          node       = NODEW'((1 << l) - 1) + NODEW'(acc_way >> (L - l));
          next[node] = ~acc_way[L-1-l];
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int s = 0; s < NUMLINES; s++) mem[s] <= '0;
        end else if (clear_en) begin
          for (int s = 0; s < NUMLINES; s++) mem[s] <= '0;
        end else if (write_en) begin
          mem[PAdr] <= next;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          curr <= '0;
        else if (clear_en)
          curr <= '0;
        else if (CacheEn)
          curr <= fwd ? next : mem[CacheSetData];
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_cache_repl_policy.sv
// ============================================================================
// tb_cache_repl_policy : directed checks of victim selection, 4-way config
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cache_repl_policy;

  logic       clk = 1'b0;
  logic       reset;
  logic       CacheEn;
  logic       FlushStage;
  logic [3:0] ValidWay;
  logic [3:0] HitWay;
  logic [6:0] CacheSetData;
  logic [6:0] PAdr;
  logic       LRUWriteEn;
  logic       SetValid;
  logic       InvalidateCache;
  logic       PolicySel;
  logic [3:0] VictimWay;

  int checks   = 0;
  int failures = 0;

  cache_repl_policy #(
    .NUMWAYS (4), .SETLEN (7), .NUMLINES (128), .LFSRLEN (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .CacheEn         (CacheEn),
    .FlushStage      (FlushStage),
    .ValidWay        (ValidWay),
    .HitWay          (HitWay),
    .CacheSetData    (CacheSetData),
    .PAdr            (PAdr),
    .LRUWriteEn      (LRUWriteEn),
    .SetValid        (SetValid),
    .InvalidateCache (InvalidateCache),
    .PolicySel       (PolicySel),
    .VictimWay       (VictimWay)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    CacheEn = 0; LRUWriteEn = 0; SetValid = 0; FlushStage = 0;
    InvalidateCache = 0; HitWay = 4'b0000;
  endtask

  task automatic lookup(input logic [6:0] set);
    idle();
    CacheEn = 1; CacheSetData = set;
    step();
    CacheEn = 0;
  endtask

  logic [3:0] rand_exp [5];

  initial begin
    rand_exp[0] = 4'b0100; rand_exp[1] = 4'b0001; rand_exp[2] = 4'b0001;
    rand_exp[3] = 4'b0010; rand_exp[4] = 4'b1000;

    reset = 1; idle(); PolicySel = 0; CacheSetData = '0; PAdr = '0; ValidWay = 4'b0000;
    step(); step();

    // Reset state, fill-invalid-first
    check("rst_inv0000", VictimWay, 4'b0001);
    ValidWay = 4'b0111; #1;
    check("rst_inv0111", VictimWay, 4'b1000);
    ValidWay = 4'b1011; #1;
    check("rst_inv1011", VictimWay, 4'b0100);
    ValidWay = 4'b1111; #1;
    check("rst_plru_all_valid", VictimWay, 4'b0001);
    reset = 0;
    step();

    // LFSR random mode
    PolicySel = 1; #1;
    check("rand_seed", VictimWay, 4'b0010);
    for (int i = 0; i < 5; i++) begin
      idle(); LRUWriteEn = 1; SetValid = 1; PAdr = 7'd9;
      step();
      check($sformatf("rand_fill%0d", i), VictimWay, rand_exp[i]);
    end
    idle(); FlushStage = 1; LRUWriteEn = 1; SetValid = 1; PAdr = 7'd9;
    step();
    check("rand_flush_hold", VictimWay, 4'b1000);
    idle();
    PolicySel = 0; #1;
    check("policy_to_plru", VictimWay, 4'b0001);
    PolicySel = 1; #1;
    check("policy_back_rand", VictimWay, 4'b1000);

    // Mid-run reset restores the seed
    reset = 1; #2; reset = 0;
    step();
    check("rand_after_reset", VictimWay, 4'b0010);

    // PLRU hits on set 5, with same-set forwarding every cycle
    PolicySel = 0;
    lookup(7'd5);
    check("plru_init", VictimWay, 4'b0001);
    for (int w = 0; w < 4; w++) begin
      idle(); CacheEn = 1; CacheSetData = 7'd5;
      LRUWriteEn = 1; PAdr = 7'd5; HitWay = 4'(1 << w);
      step();
      check($sformatf("plru_fwd_hit%0d", w), VictimWay, (w < 2) ? 4'b0100 : 4'b0001);
    end
    lookup(7'd5);
    check("plru_mem_after4", VictimWay, 4'b0001);
    idle(); CacheEn = 1; CacheSetData = 7'd5; LRUWriteEn = 1; PAdr = 7'd5; HitWay = 4'b0001;
    step();
    check("fwd_hit0", VictimWay, 4'b0100);
    idle(); step();
    check("curr_hold", VictimWay, 4'b0100);
    lookup(7'd0);
    check("other_set", VictimWay, 4'b0001);
    lookup(7'd5);
    check("plru_mem_hit0", VictimWay, 4'b0100);
    ValidWay = 4'b1101; #1;
    check("invalid_overrides_plru", VictimWay, 4'b0010);
    ValidWay = 4'b1111;

    // Non-forwarded write to set 7; Curr keeps the stale word until re-read
    lookup(7'd7);
    idle(); LRUWriteEn = 1; PAdr = 7'd7; HitWay = 4'b0010;
    step();
    check("set7_stale_curr", VictimWay, 4'b0001);
    lookup(7'd7);
    check("set7_written", VictimWay, 4'b0100);

    // Flush blocks the write but still captures
    idle(); FlushStage = 1; LRUWriteEn = 1; PAdr = 7'd7; HitWay = 4'b0100;
    CacheEn = 1; CacheSetData = 7'd7;
    step();
    check("flush_capture", VictimWay, 4'b0100);
    lookup(7'd7);
    check("flush_no_write", VictimWay, 4'b0100);

    // Invalidate under flush is ignored
    idle(); FlushStage = 1; InvalidateCache = 1;
    step();
    lookup(7'd5);
    check("inv_flushed", VictimWay, 4'b0100);

    // Invalidate wins over a simultaneous write
    idle(); InvalidateCache = 1; LRUWriteEn = 1; PAdr = 7'd5; HitWay = 4'b0100;
    step();
    check("inv_curr", VictimWay, 4'b0001);
    lookup(7'd5);
    check("inv_set5", VictimWay, 4'b0001);
    lookup(7'd7);
    check("inv_set7", VictimWay, 4'b0001);
    PolicySel = 1; #1;
    check("inv_keeps_lfsr", VictimWay, 4'b0010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
